// File: rtl/keccak_absorb.sv
// Keccak sponge absorb front-end: XORs 64-bit message words into the rate lanes,
// applies pad10*1 with a domain byte, and hands each block to the permutation.
module keccak_absorb #(
   parameter int          BW_DATA    = 1600,
   parameter int          BW_WORD    = 64,
   parameter int          RATE_LANES = 21,
   parameter logic [7:0]  DSBYTE     = 8'h1F
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_init,
   input  logic [BW_WORD-1:0] i_word,
   input  logic               i_word_valid,
   input  logic               i_word_last,
   input  logic [3:0]         i_word_bytes,
   output logic               o_word_ready,
   output logic [BW_DATA-1:0] o_lanes,
   output logic               o_valid,
   input  logic [BW_DATA-1:0] i_lanes,
   input  logic               i_valid,
   output logic [BW_DATA-1:0] o_state,
   output logic               o_done
);

   typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PERM, S_DONE} fsm_t;

   localparam logic [4:0] P_LAST = 5'(RATE_LANES - 1);

   // Rate lane i sits at x=i%5, y=i/5; the bus packs lane (x,y) at index 5x+y from the top.
   function automatic int lane_lsb(input int i);
      return BW_DATA - BW_WORD * (5 * (i % 5) + i / 5 + 1);
   endfunction

   fsm_t               fsm_q, fsm_d;
   logic [BW_DATA-1:0] state_q, state_d;
   logic [BW_DATA-1:0] ostate_q, ostate_d;
   logic [4:0]         p_q, p_d;
   logic               fin_q, fin_d;
   logic               padpend_q, padpend_d;
   logic               start_q, start_d;

   logic [3:0]         k_eff;
   logic [BW_WORD-1:0] mword;
   logic [BW_WORD-1:0] lanew;
   logic [BW_DATA-1:0] absorb_vec;
   logic [BW_DATA-1:0] pad_blk;
   logic               pad_defer;

   always_comb begin
      k_eff = 4'd8;
      if (i_word_last && (i_word_bytes < 4'd8))
         k_eff = i_word_bytes;
      mword = '0;
      for (int b = 0; b < 8; b++)
         if (4'(b) < k_eff)
            mword[8*b +: 8] = i_word[8*b +: 8];
      // A full final word that also fills the block leaves no room: pad in an extra block.
      pad_defer  = i_word_last && (k_eff == 4'd8) && (p_q == P_LAST);
      absorb_vec = '0;
      lanew      = '0;
      for (int i = 0; i < RATE_LANES; i++) begin
         lanew = (p_q == 5'(i)) ? mword : '0;
         if (i_word_last && !pad_defer) begin
            for (int b = 0; b < 8; b++)
               if ((p_q == 5'(i)) && (k_eff == 4'(b)))
                  lanew[8*b +: 8] = lanew[8*b +: 8] | DSBYTE;
            if ((k_eff == 4'd8) && ((p_q + 5'd1) == 5'(i)))
               lanew[7:0] = lanew[7:0] | DSBYTE;
            if (i == RATE_LANES - 1)
               lanew[BW_WORD-1 -: 8] = lanew[BW_WORD-1 -: 8] | 8'h80;
         end
         absorb_vec[lane_lsb(i) +: BW_WORD] = lanew;
      end
      pad_blk = '0;
      pad_blk[lane_lsb(0) +: 8] = DSBYTE;
      pad_blk[lane_lsb(RATE_LANES - 1) + BW_WORD - 8 +: 8] =
         pad_blk[lane_lsb(RATE_LANES - 1) + BW_WORD - 8 +: 8] | 8'h80;
   end

   always_comb begin
      fsm_d     = fsm_q;
      state_d   = state_q;
      ostate_d  = ostate_q;
      p_d       = p_q;
      fin_d     = fin_q;
      padpend_d = padpend_q;
      start_d   = 1'b0;
      case (fsm_q)
         S_ABSORB: begin
            if (i_word_valid) begin
               state_d = state_q ^ absorb_vec;
               if (i_word_last) begin
                  fsm_d     = S_PERM;
                  start_d   = 1'b1;
                  fin_d     = 1'b1;
                  padpend_d = pad_defer;
                  p_d       = '0;
               end else if (p_q == P_LAST) begin
                  fsm_d   = S_PERM;
                  start_d = 1'b1;
                  p_d     = '0;
               end else begin
                  p_d = p_q + 5'd1;
               end
            end
         end
         S_PERM: begin
            if (i_valid) begin
               state_d = padpend_q ? (i_lanes ^ pad_blk) : i_lanes;
               if (padpend_q) begin
                  padpend_d = 1'b0;
                  start_d   = 1'b1;
               end else if (fin_q) begin
                  fsm_d    = S_DONE;
                  ostate_d = state_d;
               end else begin
                  fsm_d = S_ABSORB;
               end
            end
         end
         S_DONE:  fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
      // A new message overrides whatever is in flight; the last result stays visible.
      if (i_init) begin
         fsm_d     = S_ABSORB;
         state_d   = '0;
         p_d       = '0;
         fin_d     = 1'b0;
         padpend_d = 1'b0;
         start_d   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         fsm_q     <= S_IDLE;
         state_q   <= '0;
         ostate_q  <= '0;
         p_q       <= '0;
         fin_q     <= 1'b0;
         padpend_q <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         state_q   <= state_d;
         ostate_q  <= ostate_d;
         p_q       <= p_d;
         fin_q     <= fin_d;
         padpend_q <= padpend_d;
         start_q   <= start_d;
      end
   end

   assign o_word_ready = (fsm_q == S_ABSORB);
   assign o_lanes      = state_q;
   assign o_valid      = start_q;
   assign o_state      = ostate_q;
   assign o_done       = (fsm_q == S_DONE);

endmodule

// File: tb/tb_keccak_absorb.sv
// Bench for keccak_absorb: identity permutation stub plus a scoreboard of
// expected permutation inputs and final states.
module tb_keccak_absorb;

   logic          clk;
   logic          rstn;
   logic          i_init;
   logic [63:0]   i_word;
   logic          i_word_valid;
   logic          i_word_last;
   logic [3:0]    i_word_bytes;
   logic          o_word_ready;
   logic [1599:0] o_lanes;
   logic          o_valid;
   logic [1599:0] i_lanes;
   logic          i_valid;
   logic [1599:0] o_state;
   logic          o_done;

   logic          stub_v, spur_v;
   logic [1599:0] stub_lanes;
   int            stub_dly;
   int            cyc, vcyc;
   int            nvalid, ndone;
   int            total, bad;
   logic [1599:0] exp_lanes[$];
   logic [1599:0] exp_state[$];

   assign i_valid = stub_v | spur_v;
   assign i_lanes = spur_v ? {1600{1'b1}} : stub_lanes;

   keccak_absorb dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_init       (i_init),
      .i_word       (i_word),
      .i_word_valid (i_word_valid),
      .i_word_last  (i_word_last),
      .i_word_bytes (i_word_bytes),
      .o_word_ready (o_word_ready),
      .o_lanes      (o_lanes),
      .o_valid      (o_valid),
      .i_lanes      (i_lanes),
      .i_valid      (i_valid),
      .o_state      (o_state),
      .o_done       (o_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
      for (int j = 0; j < 25; j++)
         chk($sformatf("%s_lane%0d", tag, j), obs[1599-64*j -: 64], exp[1599-64*j -: 64]);
   endtask

   // Place a word at rate lane index i (x=i%5, y=i/5).
   function automatic logic [1599:0] put(input logic [1599:0] v, input int i, input logic [63:0] w);
      logic [1599:0] r;
      r = v;
      r[1599-64*(5*(i%5)+i/5) -: 64] = w;
      return r;
   endfunction

   // Identity permutation: echo the captured lanes stub_dly cycles after o_valid.
   initial begin
      logic [1599:0] cap;
      stub_v     = 1'b0;
      stub_lanes = '0;
      forever begin
         @(negedge clk);
         if (rstn && o_valid) begin
            cap = o_lanes;
            repeat (stub_dly) @(posedge clk);
            #1 stub_v = 1'b1;
            stub_lanes = cap;
            @(posedge clk);
            #1 stub_v = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (o_valid) begin
               nvalid++;
               vcyc = cyc;
               if (exp_lanes.size() > 0) chk_vec("olanes", o_lanes, exp_lanes.pop_front());
               else chk("unexpected_ovalid", 64'(o_valid), 64'd0);
            end
            if (o_done) begin
               ndone++;
               chk("done_latency", 64'(cyc - vcyc), 64'(stub_dly + 1));
               if (exp_state.size() > 0) chk_vec("ostate", o_state, exp_state.pop_front());
               else chk("unexpected_done", 64'(o_done), 64'd0);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic do_init();
      i_init = 1'b1;
      @(posedge clk); #1;
      i_init = 1'b0;
   endtask

   task automatic send(input logic [63:0] w, input logic last, input logic [3:0] nb);
      int g;
      g = 0;
      while (!o_word_ready && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 200) chk("ready_timeout", 64'(o_word_ready), 64'd1);
      i_word       = w;
      i_word_last  = last;
      i_word_bytes = nb;
      i_word_valid = 1'b1;
      @(posedge clk); #1;
      i_word_valid = 1'b0;
      i_word_last  = 1'b0;
   endtask

   task automatic wait_done(input int n0);
      int g;
      g = 0;
      while (ndone == n0 && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      chk("done_seen", 64'(ndone != n0), 64'd1);
   endtask

   initial begin
      logic [1599:0] v, v2;
      logic [63:0]   w;
      int            nv0, nd0, c0;
      total = 0; bad = 0; nvalid = 0; ndone = 0; vcyc = 0;
      stub_dly = 3;
      spur_v   = 1'b0;

      // Reset with random inputs
      rstn = 1'b0;
      i_init = 1'($urandom); i_word = {$urandom, $urandom}; i_word_valid = 1'($urandom);
      i_word_last = 1'($urandom); i_word_bytes = 4'($urandom); spur_v = 1'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_vec("rst_olanes", o_lanes, '0);
      chk_vec("rst_ostate", o_state, '0);
      chk("rst_ovalid", 64'(o_valid), 64'd0);
      chk("rst_odone", 64'(o_done), 64'd0);
      chk("rst_ready", 64'(o_word_ready), 64'd0);
      i_init = 1'b0; i_word = '0; i_word_valid = 1'b0; i_word_last = 1'b0;
      i_word_bytes = '0; spur_v = 1'b0;
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", 64'(o_word_ready), 64'd0);

      // Empty message: only padding
      do_init();
      chk("ready_after_init", 64'(o_word_ready), 64'd1);
      v = put('0, 0, 64'h000000000000001F);
      v = put(v, 20, 64'h8000000000000000);
      exp_lanes.push_back(v); exp_state.push_back(v);
      nv0 = nvalid; nd0 = ndone;
      send({$urandom, $urandom}, 1'b1, 4'd0);
      wait_done(nd0);
      chk("empty_nvalid", 64'(nvalid - nv0), 64'd1);

      // Three all-ones words, last with 3 bytes
      do_init();
      v = put('0, 0, 64'hFFFFFFFFFFFFFFFF);
      v = put(v, 1, 64'hFFFFFFFFFFFFFFFF);
      v = put(v, 2, 64'h000000001FFFFFFF);
      v = put(v, 20, 64'h8000000000000000);
      exp_lanes.push_back(v); exp_state.push_back(v);
      nv0 = nvalid; nd0 = ndone;
      send('1, 1'b0, 4'd0);
      send('1, 1'b0, 4'd0);
      send('1, 1'b1, 4'd3);
      wait_done(nd0);
      chk("partial_nvalid", 64'(nvalid - nv0), 64'd1);

      // Full block ending in a full last word: extra padding block
      do_init();
      v = '0;
      for (int i = 0; i < 21; i++) v = put(v, i, 64'h0101010101010101);
      v2 = put(v, 0, 64'h010101010101011E);
      v2 = put(v2, 20, 64'h8101010101010101);
      exp_lanes.push_back(v); exp_lanes.push_back(v2); exp_state.push_back(v2);
      nv0 = nvalid; nd0 = ndone;
      c0 = cyc;
      for (int i = 0; i < 21; i++) send(64'h0101010101010101, 1'(i == 20), 4'd8);
      chk("throughput_cycles", 64'(cyc - c0), 64'd21);
      wait_done(nd0);
      chk("padpend_nvalid", 64'(nvalid - nv0), 64'd2);

      // Restart mid-block
      do_init();
      nv0 = nvalid;
      for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'b0, 4'd0);
      do_init();
      chk_vec("reinit_olanes", o_lanes, '0);
      chk("reinit_ready", 64'(o_word_ready), 64'd1);
      repeat (25) begin @(posedge clk); #1; end
      chk("reinit_nvalid", 64'(nvalid - nv0), 64'd0);

      // Slow permutation, spurious i_valid while absorbing
      stub_dly = 30;
      do_init();
      nv0 = nvalid; nd0 = ndone;
      v = '0;
      for (int i = 0; i < 21; i++) begin
         w = {$urandom, $urandom};
         v = put(v, i, w);
         if (i == 20) exp_lanes.push_back(v);
         send(w, 1'b0, 4'd0);
         if (i == 3) begin
            spur_v = 1'b1;
            @(posedge clk); #1;
            spur_v = 1'b0;
         end
      end
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         chk($sformatf("perm_ready_low%0d", i), 64'(o_word_ready), 64'd0);
      end
      @(negedge clk);
      chk("perm_ready_back", 64'(o_word_ready), 64'd1);
      chk("slow_nvalid", 64'(nvalid - nv0), 64'd1);
      @(posedge clk); #1;
      v2 = put(v, 0, v[1599 -: 64] ^ 64'h000000000000001F);
      v2 = put(v2, 20, v[1599-64*4 -: 64] ^ 64'h8000000000000000);
      exp_lanes.push_back(v2); exp_state.push_back(v2);
      send({$urandom, $urandom}, 1'b1, 4'd0);
      wait_done(nd0);
      chk("slow_total_nvalid", 64'(nvalid - nv0), 64'd2);
      stub_dly = 3;

      repeat (3) @(posedge clk);
      chk("exp_lanes_left", 64'(exp_lanes.size()), 64'd0);
      chk("exp_state_left", 64'(exp_state.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keccak_absorb.md
# keccak_absorb

Sponge absorb front-end for the Keccak-f[1600] permutation core. Accepts a message as a stream of 64-bit little-endian words, XORs each rate block into a 1600-bit state register, and applies pad10*1 with a domain-separation byte. After each full or final rate block it hands the state to the permutation and reloads the result. It sits directly upstream of the permutation and feeds its lane input.

## Interface
- BW_DATA, 1600, state width (25 lanes x 64)
- BW_WORD, 64, message word / lane width
- RATE_LANES, 21, rate in lanes (21 = SHAKE128, 17 = SHA3-256/SHAKE256, 9 = SHA3-512); legal 1..24
- DSBYTE, 8'h1F, domain-separation byte (8'h06 for SHA3)
- i_clk  in  1  clock; all logic on rising edge
- i_rstn  in  1  reset, synchronous, active-low
- i_init  in  1  clear state to zero and start a new message (1-cycle pulse)
- i_word  in  64  message word; byte 0 = bits [7:0]
- i_word_valid  in  1  word present
- i_word_last  in  1  word is the final word of the message
- i_word_bytes  in  4  valid bytes in the final word, 0..8; ignored unless i_word_last
- o_word_ready  out  1  block accepts a word this cycle
- o_lanes  out  1600  state to permutation; lane (x,y) at bits [1599-64*(5x+y) -: 64]
- o_valid  out  1  one-cycle start strobe to permutation
- i_lanes  in  1600  permutation result, same lane packing
- i_valid  in  1  permutation result valid (1-cycle pulse)
- o_state  out  1600  final absorbed state, held until next i_init
- o_done  out  1  one-cycle pulse: absorb finished, o_state valid

## Operation
- Rate lane index i = x+5y maps to x = i%5, y = i/5. Word counter p runs 0..RATE_LANES-1 and wraps to 0 after each block.
- States: IDLE, ABSORB, PERM, DONE.
  - IDLE: o_word_ready=0. i_init -> ABSORB, state=0, p=0.
  - ABSORB: o_word_ready=1. On a word accept (valid & ready), XOR the word into lane p, then p++.
    - Non-last word with p = RATE_LANES-1 -> PERM.
    - Last word -> PERM with fin=1.
  - PERM: o_valid=1 in its first cycle only, then wait for i_valid. On i_valid, state <= i_lanes (XOR padblock if padpend).
    - padpend -> PERM again, padpend=0.
    - fin -> DONE.
    - else -> ABSORB.
  - DONE: o_done=1 for one cycle, o_state <= state, then -> IDLE.
- Padding on last word, with k = i_word_bytes:
  - Bytes k..7 of the word are masked to 0 before the XOR.
  - k<8: DSBYTE XORed at byte k of lane p; 0x80 XORed at byte 7 of lane RATE_LANES-1. If both land on the same byte, the byte is XORed with DSBYTE|0x80.
  - k=8 and p<RATE_LANES-1: DSBYTE goes at byte 0 of lane p+1.
  - k=8 and p=RATE_LANES-1: the block is permuted unpadded and padpend=1. padblock = DSBYTE at lane 0 byte 0, 0x80 at lane RATE_LANES-1 byte 7.
- Capacity lanes (i >= RATE_LANES) are never written from the input.
- i_init has priority in every state: state=0, p=0, fin=padpend=0, -> ABSORB. o_state is not cleared.
- i_valid outside PERM, and i_word_valid while o_word_ready=0, are ignored.
- k>8 is treated as 8.

## Timing
- Reset (i_rstn=0 at an edge): FSM=IDLE; state, o_state, o_lanes = 0; o_valid=o_done=o_word_ready=0.
- o_lanes is driven continuously from the state register.
- Word accepted at cycle N updates state at N+1.
- Block-ending word accepted at N: o_valid=1 at N+1, o_word_ready=0 from N+1.
- i_valid at M:
  - continuing: o_word_ready=1 at M+1;
  - padpend: o_valid=1 at M+1;
  - final: o_done=1 at M+1, o_state valid from M+1.
- Throughput: one word per cycle within a block, with no bubble while i_word_valid is held.
- i_init at cycle T: o_word_ready=1 at T+1.

## Test plan
Bench uses an identity-stub permutation (i_lanes = captured o_lanes, i_valid 3 cycles after o_valid) with default parameters.
- Reset held 2 cycles with random inputs -> all outputs 0, o_word_ready=0.
- i_init; last word, bytes=0, at p=0 -> one o_valid; lane(0,0)=0x000000000000001F, lane(0,4)=0x8000000000000000, all else 0; o_done 4 cycles after o_valid, o_state equals the same value.
- i_init; words 0xFFFFFFFFFFFFFFFF x3, last has bytes=3 -> lane(0,0)=lane(1,0)=all-ones, lane(2,0)=0x000000001FFFFFFF, lane(0,4)=0x8000000000000000.
- 21 words of 0x0101010101010101, last with bytes=8 -> two o_valid pulses; second o_lanes has lane(0,0)=0x010101010101011E, lane(0,4)=0x8101010101010101.
- i_init asserted after 5 of 21 words -> o_lanes all-zero next cycle, o_word_ready=1, no o_valid.
- Stub i_valid delayed 30 cycles -> exactly one o_valid pulse, o_word_ready low throughout, spurious i_valid in ABSORB ignored.
